// File: rtl/button_debounce_multi.sv
// N-channel push-button front end: two-flop synchroniser, polarity normalisation,
// stable-time debounce, registered press/release pulses and a one-shot long press.
module button_debounce_multi #(
    parameter int N_CH       = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int STABLE     = 50000,
    parameter int CNT_W      = 16,
    parameter int HOLD       = 2**24,
    parameter int HOLD_W     = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_buttons,
    output logic [N_CH-1:0] o_state,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long_press,
    output logic            o_any_event
);

    localparam logic              POL       = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;
    logic [N_CH-1:0] w_state;
    logic [N_CH-1:0] w_done;
    logic [N_CH-1:0] r_state_d;
    logic [N_CH-1:0] r_done_d;
    logic [N_CH-1:0] r_press;
    logic [N_CH-1:0] r_release;
    logic [N_CH-1:0] r_long;

    // NOTE: non-blocking assignments make r_s2 take the old r_s1, giving two real stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_buttons ^ {N_CH{POL}};
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0]  r_cnt;
        logic [HOLD_W-1:0] r_hold;
        logic              r_state;
        logic              r_done;

        // A new level is accepted only after STABLE consecutive cycles of disagreement.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
            end else if (r_s2[g] == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_state <= r_s2[g];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Hold timer freezes once done is set, so long press fires once per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold <= '0;
                r_done <= 1'b0;
            end else if (!r_state) begin
                r_hold <= '0;
                r_done <= 1'b0;
            end else if (!r_done) begin
                if (r_hold == HOLD_LAST) begin
                    r_done <= 1'b1;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end

        assign w_state[g] = r_state;
        assign w_done[g]  = r_done;
    end

    // Edge detectors on the debounced level and the hold-done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_d <= '0;
            r_done_d  <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
        end else begin
            r_state_d <= w_state;
            r_done_d  <= w_done;
            r_press   <= w_state & ~r_state_d;
            r_release <= ~w_state & r_state_d;
            r_long    <= w_done & ~r_done_d;
        end
    end

    assign o_state      = w_state;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long;
    assign o_any_event  = |(r_press | r_release | r_long);

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: one active-low and one active-high instance run
// the same per-cycle vector table (pins inverted for the active-high copy).
module tb_button_debounce_multi;

    localparam int N_CH   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;

    typedef struct {
        logic [1:0] btn;
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_al;
    logic [1:0] btn_ah;

    logic [1:0] al_state, al_press, al_release, al_long;
    logic       al_any;
    logic [1:0] ah_state, ah_press, ah_release, ah_long;
    logic       ah_any;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    button_debounce_multi #(
        .N_CH(N_CH), .ACTIVE_LOW(1), .STABLE(STABLE), .CNT_W(16), .HOLD(HOLD), .HOLD_W(25)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .i_buttons(btn_al),
        .o_state(al_state), .o_press(al_press), .o_release(al_release),
        .o_long_press(al_long), .o_any_event(al_any)
    );

    button_debounce_multi #(
        .N_CH(N_CH), .ACTIVE_LOW(0), .STABLE(STABLE), .CNT_W(16), .HOLD(HOLD), .HOLD_W(25)
    ) dut_ah (
        .clk(clk), .rst_n(rst_n), .i_buttons(btn_ah),
        .o_state(ah_state), .o_press(ah_press), .o_release(ah_release),
        .o_long_press(ah_long), .o_any_event(ah_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {st,pr,rl,lp,any}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Append n identical cycles: pin levels (active-low view) and the outputs after that edge.
    function automatic void add(input logic [1:0] btn, input logic [1:0] st, input logic [1:0] pr,
                                input logic [1:0] rl, input logic [1:0] lp, input int n,
                                input string name);
        vec_t v;
        v.btn  = btn;
        v.st   = st;
        v.pr   = pr;
        v.rl   = rl;
        v.lp   = lp;
        v.name = name;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic run_vectors();
        while (vecs.size() > 0) begin
            vec_t v;
            vec_t e;
            logic [8:0] exp_bits;
            v = vecs.pop_front();
            btn_al = v.btn;
            btn_ah = ~v.btn;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            exp_bits = {e.st, e.pr, e.rl, e.lp, |(e.pr | e.rl | e.lp)};
            check({e.name, "/al"}, {al_state, al_press, al_release, al_long, al_any}, exp_bits);
            check({e.name, "/ah"}, {ah_state, ah_press, ah_release, ah_long, ah_any}, exp_bits);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_al = 2'b11;
        btn_ah = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset/al", {al_state, al_press, al_release, al_long, al_any}, 9'd0);
        check("reset/ah", {ah_state, ah_press, ah_release, ah_long, ah_any}, 9'd0);
        rst_n = 1'b1;

        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 4,  "idle_after_reset");
        // press ch0 and hold well past the long-press point, then release
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "t1_wait");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1,  "t1_state");
        add(2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1,  "t1_press");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 9,  "t3_hold");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1,  "t3_long");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 12, "t3_no_second");
        add(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5,  "t3_rel_wait");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  "t3_rel_state");
        add(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1,  "t3_release");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 4,  "t3_idle");
        // glitch one cycle shorter than STABLE
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3,  "t2_glitch");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 10, "t2_quiet");
        // short press: released before the hold timer expires
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "t4_wait");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1,  "t4_state");
        add(2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1,  "t4_press");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1,  "t4_held");
        add(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5,  "t4_rel_wait");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  "t4_rel_state");
        add(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1,  "t4_release");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 12, "t4_no_long");
        // channel 1 alone
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "ch1_wait");
        add(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1,  "ch1_state");
        add(2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1,  "ch1_press");
        add(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 5,  "ch1_rel_wait");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  "ch1_rel_state");
        add(2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 1,  "ch1_release");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 12, "ch1_idle");
        // both channels together
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "t5_wait");
        add(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1,  "t5_state");
        add(2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1,  "t5_press");
        add(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 9,  "t5_hold");
        add(2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 1,  "t5_long");
        add(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 3,  "t5_held");
        add(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 5,  "t5_rel_wait");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  "t5_rel_state");
        add(2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1,  "t5_release");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3,  "t5_idle");
        // lead-in to the mid-hold reset
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "t6_pre_wait");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1,  "t6_pre_state");
        add(2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1,  "t6_pre_press");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 5,  "t6_pre_hold");
        run_vectors();

        // asynchronous reset between edges while the pin is still held
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async/al", {al_state, al_press, al_release, al_long, al_any}, 9'd0);
        check("t6_async/ah", {ah_state, ah_press, ah_release, ah_long, ah_any}, 9'd0);
        @(posedge clk);
        #1;
        check("t6_in_reset/al", {al_state, al_press, al_release, al_long, al_any}, 9'd0);
        check("t6_in_reset/ah", {ah_state, ah_press, ah_release, ah_long, ah_any}, 9'd0);
        rst_n = 1'b1;

        // held through reset: full debounce and full hold time again, no stale progress
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5,  "t6_wait");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1,  "t6_state");
        add(2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1,  "t6_press");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 9,  "t6_hold");
        add(2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1,  "t6_long");
        add(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5,  "t6_rel_wait");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  "t6_rel_state");
        add(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1,  "t6_release");
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3,  "t6_idle");
        run_vectors();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog timeout");
    end

endmodule
